uart_tx_io: RTL and testbench
=============================

UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter BASE_ADDR, default 'h100, byte address of the TXDATA register; STATUS is at BASE_ADDR+4.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 2..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dataAddr  input  DataAddrPath  data-bus address from the CPU.
REQ-007 dataOut  input  DataPath (32)  CPU write data.
REQ-008 dataWrEnable  input  1  CPU write strobe, one write per asserted cycle.
REQ-009 ioRdData  output  DataPath (32)  read data for a hit address, zero otherwise.
REQ-010 ioHit  output  1  high when dataAddr equals TXDATA or STATUS address.
REQ-011 txd  output  1  serial output line, idle high.

Function
REQ-012 Address decode, read data and ioHit shall be combinational from dataAddr and current state, no latency.
REQ-013 Reading STATUS shall return bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 sticky overflow, bits[8:4] FIFO count, all other bits zero.
REQ-014 Reading TXDATA shall return zero.
REQ-015 A write to TXDATA with count<FIFO_DEPTH shall push dataOut[7:0] at the clock edge; dataOut[31:8] are ignored.
REQ-016 A write to TXDATA when count==FIFO_DEPTH shall drop the byte and set overflow, even if a pop occurs in the same cycle.
REQ-017 A write to STATUS with dataOut[3]=1 shall clear overflow; other STATUS bits are read-only. If it coincides with a new overflow event, the event wins and overflow stays set.
REQ-018 Simultaneous push and pop shall leave count unchanged; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, START, DATA, STOP; a bit counter (0..CLKS_PER_BIT-1) and a data-bit index (0..7) pace it.
REQ-020 IDLE: txd=1. When FIFO is non-empty, pop the head into a shift register and go to START on the next edge.
REQ-021 START: txd=0 for CLKS_PER_BIT cycles, then DATA with index 0.
REQ-022 DATA: txd=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shifts right. After index 7 completes, go to STOP.
REQ-023 STOP: txd=1 for CLKS_PER_BIT cycles. Then pop and go to START directly if the FIFO is non-empty (back-to-back frames, no extra idle cycle), else go to IDLE.
REQ-024 Frame length shall be exactly 10*CLKS_PER_BIT cycles; txd shall be driven from a flop (glitch-free).
REQ-025 A byte pushed into an empty FIFO while in IDLE shall start its START bit on txd at the second edge after the write edge (push edge, then pop edge).
REQ-026 Writes to addresses other than TXDATA/STATUS shall have no effect.

Reset
REQ-027 Asserting rst at any time, including mid-frame, shall immediately force txd=1, FSM=IDLE, FIFO empty (count 0, pointers 0), overflow=0, and bit counter/index=0.
REQ-028 During and after reset, until the first write, STATUS shall read 'h4 (empty only).
REQ-029 Bytes in flight or queued at reset are discarded; no partial frame resumes after reset release.

Verification
REQ-030 Reset, then read STATUS -> 'h4; txd=1; ioHit=1 at BASE_ADDR+4, 0 at BASE_ADDR+8.
REQ-031 Write 'hA5 to TXDATA (CLKS_PER_BIT=4) -> txd sequence start 0, bits 1,0,1,0,0,1,0,1, stop 1, each bit 4 cycles. Frame spans 40 cycles; STATUS busy=1 throughout, then 'h4.
REQ-032 Write 'h11,'h22,'h33 on consecutive cycles -> three frames back-to-back with no idle cycle between STOP and START. Count reads 2 after the first pop.
REQ-033 Write 6 bytes on consecutive cycles with FIFO_DEPTH=4 -> first byte popped; bytes 2-5 fill the FIFO; byte 6 is dropped; overflow=1; exactly 5 frames are sent.
REQ-034 Write STATUS with 'h8 -> overflow clears. With a simultaneous full-FIFO TXDATA write in the same cycle, overflow stays 1.
REQ-035 Assert rst in the DATA state of frame 1 with 2 bytes queued -> txd=1 in the same cycle. After release, STATUS='h4 and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO, flopped serializer.
// Reads are combinational; first START bit 2 edges after the write; a write to a full FIFO is dropped and flags overflow.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_rdy_i,
  output logic [W-1:0]     head_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_vld_i && !full_o;
  assign do_pop     = pop_rdy_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module uart_tx_io #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h100,
  parameter int                CLKS_PER_BIT = 4,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [31:0]       dataOut,
  input  logic              dataWrEnable,
  output logic [31:0]       ioRdData,
  output logic              ioHit,
  output logic              txd
);
  localparam logic [ADDR_W-1:0] STAT_ADDR = BASE_ADDR + ADDR_W'(4);
  localparam int                CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     LAST_TICK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    tick_q, tick_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ovf_q, ovf_d;
  logic             hit_tx, hit_st, wr_tx, wr_st;
  logic             pop, full, empty;
  logic [7:0]       head;
  logic [CNT_W-1:0] count;
  logic             unused_hi;

  assign hit_tx    = (dataAddr == BASE_ADDR);
  assign hit_st    = (dataAddr == STAT_ADDR);
  assign ioHit     = hit_tx || hit_st;
  assign wr_tx     = dataWrEnable && hit_tx;
  assign wr_st     = dataWrEnable && hit_st;
  assign txd       = txd_q;
  assign unused_hi = ^{dataOut[31:8], dataOut[7:4], dataOut[2:0]};

  uart_tx_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_vld_i (wr_tx),
    .push_dat_i (dataOut[7:0]),
    .pop_rdy_i  (pop),
    .head_dat_o (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    ioRdData = '0;
    if (hit_st) ioRdData = {23'b0, 5'(count), ovf_q, empty, full, state_q != IDLE};
  end

  // A new overflow event outranks a clear landing in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_st && dataOut[3]) ovf_d = 1'b0;
    if (wr_tx && full)       ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tick_d  = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      DATA: begin
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      STOP: begin
        if (tick_q == LAST_TICK) begin
          tick_d = '0;
          idx_d  = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from next state so txd comes straight off a flop.
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io: register decode table, then frame, back-to-back,
// overflow and mid-frame reset sequences checked against a recorded txd trace.
module tb_uart_tx_io;
  localparam int          CPB = 4;
  localparam logic [31:0] TXA = 32'h100;
  localparam logic [31:0] STA = 32'h104;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataAddr, dataOut, ioRdData;
  logic        dataWrEnable, ioHit, txd;

  int   total = 0;
  int   bad   = 0;
  logic rec_on = 1'b0;
  logic trace[$];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdat;
    logic        hit;
    logic [31:0] rd;
  } vec_t;
  vec_t vt[10];

  uart_tx_io #(
    .ADDR_W       (32),
    .BASE_ADDR    (32'h100),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (dataAddr),
    .dataOut      (dataOut),
    .dataWrEnable (dataWrEnable),
    .ioRdData     (ioRdData),
    .ioHit        (ioHit),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (rec_on) trace.push_back(txd);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_st(output logic [31:0] d);
    dataAddr     = STA;
    dataWrEnable = 1'b0;
    #1;
    d = ioRdData;
  endtask

  task automatic chk_st(input string name, input logic [31:0] exp);
    logic [31:0] d;
    rd_st(d);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dataAddr     = a;
    dataOut      = d;
    dataWrEnable = 1'b1;
    @(negedge clk);
    dataWrEnable = 1'b0;
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i / CPB];
    return r;
  endfunction

  function automatic logic [39:0] tr40(input int base);
    logic [39:0] r;
    for (int i = 0; i < 40; i++) r[i] = (base + i < trace.size()) ? trace[base + i] : 1'bx;
    return r;
  endfunction

  function automatic int zeros(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to; i++) if (i >= trace.size() || trace[i] !== 1'b1) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] d;
    logic        busy_all;
    logic [7:0]  ob[6];
    int          mark;

    vt[0] = '{32'h104, 1'b0, 32'h0,        1'b1, 32'h4};
    vt[1] = '{32'h100, 1'b0, 32'h0,        1'b1, 32'h0};
    vt[2] = '{32'h108, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[3] = '{32'h0FC, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[4] = '{32'h101, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[5] = '{32'h108, 1'b1, 32'hFF,       1'b0, 32'h0};
    vt[6] = '{32'h104, 1'b0, 32'h0,        1'b1, 32'h4};
    vt[7] = '{32'h104, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h4};
    vt[8] = '{32'h104, 1'b0, 32'h0,        1'b1, 32'h4};
    vt[9] = '{32'h100, 1'b0, 32'h0,        1'b0 | 1'b1, 32'h0};

    rst          = 1'b1;
    dataAddr     = STA;
    dataOut      = '0;
    dataWrEnable = 1'b0;
    #1;
    chk("status_in_reset", ioRdData, 32'h4);
    chk("txd_in_reset", txd, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      dataAddr     = vt[i].addr;
      dataOut      = vt[i].wdat;
      dataWrEnable = vt[i].we;
      #1;
      chk($sformatf("vec%0d_hit", i), ioHit, vt[i].hit);
      chk($sformatf("vec%0d_rd", i), ioRdData, vt[i].rd);
      @(negedge clk);
      dataWrEnable = 1'b0;
    end
    chk("txd_idle_after_table", txd, 1'b1);

    // Single frame, upper write-data bits must be ignored.
    trace.delete();
    rec_on = 1'b1;
    wr(TXA, 32'hFFFF_FFA5);
    chk_st("status_after_push", 32'h10);
    @(negedge clk);
    busy_all = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rd_st(d);
      if (d[0] !== 1'b1) busy_all = 1'b0;
      @(negedge clk);
    end
    chk("busy_through_frame", busy_all, 1'b1);
    chk_st("status_after_frame", 32'h4);
    repeat (6) @(negedge clk);
    rec_on = 1'b0;
    chk("a5_frame", tr40(2), frame_bits(8'hA5));
    chk("a5_frame_literal", tr40(2), {{4{1'b1}}, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}},
                                      {4{1'b0}}, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}}});
    chk("a5_idle_around", zeros(0, 2) + zeros(42, 48), 0);

    // Three back-to-back frames.
    trace.delete();
    rec_on = 1'b1;
    wr(TXA, 32'h11);
    wr(TXA, 32'h22);
    wr(TXA, 32'h33);
    chk_st("status_count2", 32'h21);
    repeat (125) @(negedge clk);
    rec_on = 1'b0;
    chk("b2b_frame0", tr40(2),  frame_bits(8'h11));
    chk("b2b_frame1", tr40(42), frame_bits(8'h22));
    chk("b2b_frame2", tr40(82), frame_bits(8'h33));
    chk("b2b_idle_after", zeros(122, 128), 0);
    chk_st("status_after_b2b", 32'h4);

    // Six writes into a 4-deep FIFO: sixth byte dropped.
    ob = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hFF};
    trace.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 6; i++) wr(TXA, {24'h0, ob[i]});
    chk_st("status_full_ovf", 32'h4B);
    repeat (204) @(negedge clk);
    rec_on = 1'b0;
    for (int k = 0; k < 5; k++) chk($sformatf("ovf_frame%0d", k), tr40(2 + 40 * k), frame_bits(ob[k]));
    chk("no_sixth_frame", zeros(202, 210), 0);
    chk_st("status_ovf_sticky", 32'hC);
    wr(STA, 32'h7);
    chk_st("ovf_not_cleared_bit3_0", 32'hC);
    wr(STA, 32'h8);
    chk_st("ovf_cleared", 32'h4);

    // Reset in the DATA state of frame 1 with two bytes queued.
    trace.delete();
    rec_on = 1'b1;
    wr(TXA, 32'h00);
    wr(TXA, 32'h81);
    wr(TXA, 32'h42);
    repeat (12) @(negedge clk);
    chk("txd_mid_data", txd, 1'b0);
    chk_st("status_mid_frame", 32'h21);
    rst = 1'b1;
    #1;
    chk("txd_forced_by_reset", txd, 1'b1);
    chk_st("status_during_reset", 32'h4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_st("status_after_reset", 32'h4);
    mark = trace.size();
    repeat (60) @(negedge clk);
    rec_on = 1'b0;
    chk("no_frames_after_reset", zeros(mark, trace.size()), 0);
    chk_st("status_idle_after_reset", 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
